// File: rtl/decim_chain_ctrl.sv
// Run-control sequencer for the CIC -> half-band chain: flush, warm-up discard, forward, stall watchdog.
// Define DECIM_OUT_CLIP_EN to saturate the forwarded word instead of wrapping it.
module decim_chain_ctrl #(
    parameter int DATA_W         = 33,
    parameter int OUT_W          = 24,
    parameter int FLUSH_CYCLES   = 8,
    parameter int WARMUP_SAMPLES = 16,
    parameter int TIMEOUT        = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cic_valid,
    input  logic              hbf_valid,
    input  logic [DATA_W-1:0] hbf_out,
    output logic              filt_rst,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic [1:0]        state,
    output logic [15:0]       sample_cnt,
    output logic              stall_err,
    output logic              clip_flag
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WC_W = $clog2(WARMUP_SAMPLES + 1);
    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WARM_LOAD  = WC_W'(WARMUP_SAMPLES);
    // Trip on the cycle whose increment would reach TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WC_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [15:0]     sample_cnt_q, sample_cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            stall_err_q, stall_err_d;
    logic            wd_active, wd_trip;

    logic [OUT_W-1:0] conv;
    logic             conv_clip;

`ifdef DECIM_OUT_CLIP_EN
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [DATA_W-OUT_W:0] hi_bits;
    logic                  fits;
    logic                  clip_flag_q, clip_flag_d;

    always_comb begin
        hi_bits   = hbf_out[DATA_W-1:OUT_W-1];
        fits      = (&hi_bits) | ~(|hi_bits);
        conv      = fits ? hbf_out[OUT_W-1:0] : (hbf_out[DATA_W-1] ? OUT_MIN : OUT_MAX);
        conv_clip = ~fits;
    end

    assign clip_flag = clip_flag_q;
`else
    logic unused_hi;

    always_comb begin
        conv      = hbf_out[OUT_W-1:0];
        conv_clip = 1'b0;
    end

    assign unused_hi = ^{hbf_out[DATA_W-1:OUT_W], conv_clip};
    assign clip_flag = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        warm_cnt_d   = warm_cnt_q;
        sample_cnt_d = sample_cnt_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        stall_err_d  = stall_err_q;
`ifdef DECIM_OUT_CLIP_EN
        clip_flag_d  = clip_flag_q;
`endif
        wd_active = (state_q == ST_WARMUP) || (state_q == ST_RUN);
        wd_trip   = wd_active && !cic_valid && (wd_cnt_q == WD_LAST);
        if (wd_active && !cic_valid) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = '0;
        end

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (wd_trip) begin
            state_d      = ST_FLUSH;
            flush_cnt_d  = FLUSH_LOAD;
            sample_cnt_d = '0;
            stall_err_d  = 1'b1;
            wd_cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_FLUSH;
                    flush_cnt_d  = FLUSH_LOAD;
                    sample_cnt_d = '0;
                    stall_err_d  = 1'b0;
`ifdef DECIM_OUT_CLIP_EN
                    clip_flag_d  = 1'b0;
`endif
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d    = ST_WARMUP;
                        warm_cnt_d = WARM_LOAD;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                    end
                end
                ST_WARMUP: begin
                    if (hbf_valid) begin
                        warm_cnt_d = warm_cnt_q - WC_W'(1);
                        if (warm_cnt_q == WC_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (hbf_valid) begin
                        out_d        = conv;
                        out_valid_d  = 1'b1;
                        sample_cnt_d = sample_cnt_q + 16'd1;
`ifdef DECIM_OUT_CLIP_EN
                        clip_flag_d  = clip_flag_q | conv_clip;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            warm_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            sample_cnt_q <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            stall_err_q  <= 1'b0;
`ifdef DECIM_OUT_CLIP_EN
            clip_flag_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            stall_err_q  <= stall_err_d;
`ifdef DECIM_OUT_CLIP_EN
            clip_flag_q  <= clip_flag_d;
`endif
        end
    end

    assign filt_rst   = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign state      = state_q;
    assign sample_cnt = sample_cnt_q;
    assign stall_err  = stall_err_q;

endmodule
